scroll_marquee: RTL
===================

Name: scroll_marquee

Overview:
- Parametrised scrolling marquee for an N-digit seven-segment bank.
- Holds a writable message of MSG_LEN character codes and scrolls it across NUM_DIGITS digits, one position per prescaler tick.
- Supports direction select, continuous or one-shot mode, start/stop control and runtime message load.
- Sits between the board clock and the HEX outputs; one character-decoder instance drives each digit.

Parameters:
- NUM_DIGITS, 8: number of display digits (≥2).
- MSG_LEN, 5: message buffer length in characters (≥1).
- CHAR_W, 4: character code width.
- DIV, 50_000_000: clock cycles per scroll step (≥2).
- BLANK_CODE, 15: character code that lights no segments.
- AUTO_START, 1: 1 = state after reset is RUN; 0 = IDLE.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- clr  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse: IDLE/DONE -> RUN.
- stop  in  1  one-cycle pulse: RUN -> IDLE; pos is held.
- dir  in  1  0 = text moves left (pos increments); 1 = text moves right (pos decrements).
- one_shot  in  1  1 = stop after one full cycle.
- msg_we  in  1  message write strobe.
- msg_addr  in  clog2(MSG_LEN)  write index; writes with msg_addr ≥ MSG_LEN are ignored.
- msg_data  in  CHAR_W  character written.
- chars  out  NUM_DIGITS*CHAR_W  per-digit codes; digit k occupies bits [k*CHAR_W +: CHAR_W]; digit 0 is rightmost.
- seg  out  NUM_DIGITS*7  active-low segments, digit k at [k*7 +: 7], bit order g..a.
- pos  out  clog2(MSG_LEN+NUM_DIGITS)  current scroll position.
- step  out  1  high for exactly the cycle in which a new pos first appears.
- done  out  1  one-shot completion flag.
- running  out  1  high while state == RUN.

Behaviour:
- Tape: length L = MSG_LEN + NUM_DIGITS. tape[j] = msg[j] for j < MSG_LEN, otherwise BLANK_CODE.
- Window mapping: digit k shows tape[(pos + NUM_DIGITS-1-k) mod L]. chars and seg are combinational from pos and msg; no extra latency.
- Reset (clr=1 at a clk edge):
  - pos = 0, prescaler = 0, step = 0, done = 0.
  - msg[j] = j mod 16.
  - state = RUN if AUTO_START, else IDLE.
  - clr overrides every other input in that cycle.
- Prescaler:
  - Counts 0..DIV-1 only in RUN; held at 0 in IDLE and DONE, and cleared on entry to RUN.
  - tick = (state == RUN) && (cnt == DIV-1).
- Step:
  - On tick, pos moves one place: dir=0 gives pos+1, wrapping L-1 -> 0; dir=1 gives pos-1, wrapping 0 -> L-1.
  - step is registered and is high in the cycle the new pos is visible.
  - The first step occurs DIV cycles after entering RUN.
- State machine, states IDLE, RUN, DONE:
  - IDLE: start goes to RUN.
  - RUN: stop goes to IDLE. If one_shot=1 and a tick moves pos to 0, go to DONE and set done=1.
  - DONE: pos is frozen at 0; start goes to RUN and clears done.
  - stop and start in the same cycle: stop wins (RUN -> IDLE; IDLE and DONE stay put).
- Mid-run changes:
  - dir and one_shot are sampled on each tick; a change mid-run takes effect at the next step.
  - Clearing one_shot while in DONE does not leave DONE.
- Message write:
  - msg[msg_addr] is updated on the clk edge; the display reflects it in the following cycle.
  - A write coinciding with a tick applies both.
  - Writes are accepted in every state.

Decomposition:
- Shared package (marquee_pkg): state encoding (IDLE, RUN, DONE), the default BLANK_CODE, and the 16-entry character-to-segment constant table (codes 0-9, A, b, C, d, E, blank).
- Sub-module seg_char_dec: CHAR_W code in, 7-bit active-low segments out, purely combinational, instantiated NUM_DIGITS times via generate.

Test Plan (DIV=4, defaults otherwise):
- Reset then run:
  - clr for 2 cycles -> pos=0; digits 7..0 = 0,1,2,3,4,blank,blank,blank.
  - step first high 4 cycles after clr falls; pos=1; digits = 1,2,3,4,blank×4.
- Wrap and window:
  - Continue 12 steps -> pos sequence 2..12 then 0.
  - At pos 9 digits = blank×4,0,1,2,3; at pos 12 digits = blank,0,1,2,3,4,blank,blank.
- Direction:
  - From pos=0 set dir=1 -> next step pos=12, then 11.
  - Toggle dir mid-interval -> applies at next tick only.
- One-shot:
  - one_shot=1 from pos=10, dir=0 -> steps to 11, 12, 0; done=1 and running=0.
  - pos stays 0 for 20 cycles; start -> done=0, next step pos=1.
- Control collisions:
  - stop+start in the same cycle during RUN -> IDLE, pos held, no step for 10 cycles.
  - clr asserted mid-interval -> pos=0, cnt=0 on the next edge.
- Message load:
  - Write addr=2 data=0xE on the same cycle as a tick -> pos advances and the new char shows next cycle.
  - Write addr=7 -> ignored.
  - Write data=15 -> digit shows seg=7'b1111111.

Source files
------------

// File: rtl/marquee_pkg.sv
// Shared definitions for the scrolling marquee: state encoding, default blank
// code and the character-to-segment lookup table.
package marquee_pkg;

    // Controller states
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    // Character code that lights no segments
    localparam int unsigned DefaultBlankCode = 15;

    // All segments off (active-low)
    localparam logic [6:0] SegBlank = 7'b1111111;

    // Active-low segments, bit order g..a, indexed by character code
    localparam logic [6:0] SegTable [16] = '{
        7'h40, // 0
        7'h79, // 1
        7'h24, // 2
        7'h30, // 3
        7'h19, // 4
        7'h12, // 5
        7'h02, // 6
        7'h78, // 7
        7'h00, // 8
        7'h10, // 9
        7'h08, // A
        7'h03, // b
        7'h46, // C
        7'h21, // d
        7'h06, // E
        7'h7F  // blank
    };

    // Map a 4-bit character code to its segment pattern
    function automatic logic [6:0] char_to_seg(input logic [3:0] code);
        return SegTable[code];
    endfunction

endpackage

// File: rtl/seg_char_dec.sv
// Combinational character decoder for one seven-segment digit.
// Codes outside the 16-entry table decode to blank.
module seg_char_dec
    import marquee_pkg::*;
#(
    parameter int unsigned CHAR_W = 4
) (
    input  logic [CHAR_W-1:0] code_i,
    output logic [6:0]        seg_o
);

    logic [31:0] code_ext;

    // Table lookup with out-of-range codes forced blank
    always_comb begin
        code_ext = 32'(code_i);
        if (code_ext < 32'd16) begin
            seg_o = char_to_seg(code_ext[3:0]);
        end else begin
            seg_o = SegBlank;
        end
    end

endmodule

// File: rtl/scroll_marquee.sv
// Scrolling marquee: a writable message followed by NUM_DIGITS blanks forms a
// circular tape, and a NUM_DIGITS-wide window over it advances one place per
// prescaler tick. Supports direction, one-shot mode and start/stop control.
module scroll_marquee
    import marquee_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned MSG_LEN    = 5,
    parameter int unsigned CHAR_W     = 4,
    parameter int unsigned DIV        = 50_000_000,
    parameter int unsigned BLANK_CODE = DefaultBlankCode,
    parameter bit          AUTO_START = 1'b1,
    localparam int unsigned TapeLen   = MSG_LEN + NUM_DIGITS,
    localparam int unsigned AddrW     = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1,
    localparam int unsigned PosW      = $clog2(TapeLen)
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         dir,
    input  logic                         one_shot,
    input  logic                         msg_we,
    input  logic [AddrW-1:0]             msg_addr,
    input  logic [CHAR_W-1:0]            msg_data,
    output logic [NUM_DIGITS*CHAR_W-1:0] chars,
    output logic [NUM_DIGITS*7-1:0]      seg,
    output logic [PosW-1:0]              pos,
    output logic                         step,
    output logic                         done,
    output logic                         running
);

    localparam int unsigned CntW = $clog2(DIV);
    // Wide enough to hold pos + NUM_DIGITS-1 before the modulo fold
    localparam int unsigned IdxW = $clog2(2 * TapeLen);
    localparam logic [1:0]  ResetState = AUTO_START ? StRun : StIdle;

    logic [1:0]        state_q, state_d;
    logic [PosW-1:0]   pos_q, pos_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              step_q, step_d;
    logic              done_q, done_d;
    logic [CHAR_W-1:0] msg_q [MSG_LEN];

    logic              tick;
    logic [PosW-1:0]   pos_next;

    assign tick = (state_q == StRun) && (cnt_q == CntW'(DIV - 1));

    // Neighbouring position in the selected direction, wrapping around the tape
    always_comb begin
        if (dir) begin
            pos_next = (pos_q == '0) ? PosW'(TapeLen - 1) : pos_q - 1'b1;
        end else begin
            pos_next = (pos_q == PosW'(TapeLen - 1)) ? '0 : pos_q + 1'b1;
        end
    end

    // Controller next-state: stop wins over start, the prescaler only runs in RUN
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        cnt_d   = '0;
        step_d  = 1'b0;
        done_d  = done_q;
        case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (tick) begin
                    pos_d  = pos_next;
                    step_d = 1'b1;
                    if (one_shot && (pos_next == '0)) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                pos_d = '0;
                if (start && !stop) begin
                    state_d = StRun;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Controller state registers
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ResetState;
            pos_q   <= '0;
            cnt_q   <= '0;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            done_q  <= done_d;
        end
    end

    // Message buffer: resets to an ascending pattern, out-of-range writes dropped
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int unsigned j = 0; j < MSG_LEN; j++) begin
                msg_q[j] <= CHAR_W'(j % 16);
            end
        end else if (msg_we && (32'(msg_addr) < MSG_LEN)) begin
            msg_q[msg_addr] <= msg_data;
        end
    end

    // One window tap and decoder per digit; digit 0 is rightmost
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        logic [IdxW-1:0]   sum;
        logic [IdxW-1:0]   idx;
        logic [CHAR_W-1:0] ch;

        // Tape lookup for this digit; positions past the message are blank
        always_comb begin
            sum = IdxW'(pos_q) + IdxW'(NUM_DIGITS - 1 - k);
            idx = (sum >= IdxW'(TapeLen)) ? sum - IdxW'(TapeLen) : sum;
            if (idx < IdxW'(MSG_LEN)) begin
                ch = msg_q[idx[AddrW-1:0]];
            end else begin
                ch = CHAR_W'(BLANK_CODE);
            end
        end

        assign chars[k*CHAR_W +: CHAR_W] = ch;

        seg_char_dec #(
            .CHAR_W (CHAR_W)
        ) u_dec (
            .code_i (ch),
            .seg_o  (seg[k*7 +: 7])
        );
    end

    assign pos     = pos_q;
    assign step    = step_q;
    assign done    = done_q;
    assign running = (state_q == StRun);

endmodule
